// File: rtl/fpaddsub_normalize_ctrl_if.sv
// Bundle of operand, shifter and result signals for the normalization sequencer.
// The controller uses the slave modport; the surrounding pipeline uses master.
interface fpaddsub_normalize_ctrl_if #(
  parameter int MW = 33,
  parameter int EW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] in_mant;
  logic [EW-1:0] in_exp;
  logic [MW-1:0] sh_mant_o;
  logic [4:0]    sh_amt_o;
  logic [MW-1:0] sh_mant_i;
  logic          out_valid;
  logic          out_ready;
  logic [MW-1:0] out_mant;
  logic [EW-1:0] out_exp;
  logic          out_zero;
  logic          out_denorm;
  logic [2:0]    out_passes;

  modport slave (
    input  in_valid, in_mant, in_exp, sh_mant_i, out_ready,
    output in_ready, sh_mant_o, sh_amt_o, out_valid, out_mant, out_exp,
           out_zero, out_denorm, out_passes
  );

  modport master (
    output in_valid, in_mant, in_exp, sh_mant_i, out_ready,
    input  in_ready, sh_mant_o, sh_amt_o, out_valid, out_mant, out_exp,
           out_zero, out_denorm, out_passes
  );
endinterface

// File: rtl/fpaddsub_normalize_ctrl.sv
// Multi-pass normalization sequencer: drives a shared left shifter (<= MAXSH bits
// per pass) until the mantissa MSB is set or the exponent reaches 1.
module fpaddsub_normalize_ctrl #(
  parameter int MW    = 33,
  parameter int EW    = 8,
  parameter int MAXSH = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  fpaddsub_normalize_ctrl_if.slave      bus_if
);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_SHIFT, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [MW-1:0] mant_q, mant_d;
  logic [EW-1:0] exp_q, exp_d;
  logic [3:0]    amt_q, amt_d;
  logic [2:0]    pass_q, pass_d;
  logic          zero_q, zero_d;
  logic          denorm_q, denorm_d;
  logic [5:0]    lz_s;
  logic [EW-1:0] lz_ext_s;
  logic [EW-1:0] exp_m1_s;
  logic [EW-1:0] amt_min_s;
  logic          done_s;

  function automatic logic [5:0] lzc(input logic [MW-1:0] v);
    logic       found;
    logic [5:0] cnt;
    found = 1'b0;
    cnt   = 6'd0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (found) begin
        cnt = cnt;
      end else if (v[i]) begin
        found = 1'b1;
      end else begin
        cnt = cnt + 6'd1;
      end
    end
    return cnt;
  endfunction

  // Shift amount for this pass: min(lz, MAXSH, exp-1) so the exponent never drops below 1.
  always_comb begin
    lz_s      = lzc(mant_q);
    lz_ext_s  = EW'(lz_s);
    exp_m1_s  = exp_q - {{(EW-1){1'b0}}, 1'b1};
    amt_min_s = EW'(MAXSH);
    if (lz_ext_s < amt_min_s) begin
      amt_min_s = lz_ext_s;
    end else begin
      amt_min_s = amt_min_s;
    end
    if (exp_m1_s < amt_min_s) begin
      amt_min_s = exp_m1_s;
    end else begin
      amt_min_s = amt_min_s;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    mant_d   = mant_q;
    exp_d    = exp_q;
    amt_d    = amt_q;
    pass_d   = pass_q;
    zero_d   = zero_q;
    denorm_d = denorm_q;
    case (state_q)
      S_IDLE: begin
        if (bus_if.in_valid) begin
          mant_d   = bus_if.in_mant;
          exp_d    = bus_if.in_exp;
          amt_d    = 4'd0;
          pass_d   = 3'd0;
          zero_d   = 1'b0;
          denorm_d = 1'b0;
          state_d  = S_EVAL;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_EVAL: begin
        if (mant_q == {MW{1'b0}}) begin
          zero_d   = 1'b1;
          denorm_d = 1'b0;
          exp_d    = {EW{1'b0}};
          state_d  = S_DONE;
        end else if ((lz_s == 6'd0) || (exp_q <= {{(EW-1){1'b0}}, 1'b1})) begin
          denorm_d = ~mant_q[MW-1];
          state_d  = S_DONE;
        end else begin
          amt_d    = amt_min_s[3:0];
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        mant_d  = bus_if.sh_mant_i;
        exp_d   = exp_q - {{(EW-4){1'b0}}, amt_q};
        pass_d  = pass_q + 3'd1;
        state_d = S_EVAL;
      end
      S_DONE: begin
        if (bus_if.out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mant_q   <= {MW{1'b0}};
      exp_q    <= {EW{1'b0}};
      amt_q    <= 4'd0;
      pass_q   <= 3'd0;
      zero_q   <= 1'b0;
      denorm_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mant_q   <= mant_d;
      exp_q    <= exp_d;
      amt_q    <= amt_d;
      pass_q   <= pass_d;
      zero_q   <= zero_d;
      denorm_q <= denorm_d;
    end
  end

  // Outputs come only from registers gated by the state decode.
  assign done_s            = (state_q == S_DONE);
  assign bus_if.in_ready   = (state_q == S_IDLE);
  assign bus_if.sh_mant_o  = mant_q;
  assign bus_if.sh_amt_o   = (state_q == S_SHIFT) ? {1'b0, amt_q} : 5'd0;
  assign bus_if.out_valid  = done_s;
  assign bus_if.out_mant   = done_s ? mant_q : {MW{1'b0}};
  assign bus_if.out_exp    = done_s ? exp_q : {EW{1'b0}};
  assign bus_if.out_zero   = done_s & zero_q;
  assign bus_if.out_denorm = done_s & denorm_q & ~zero_q;
  assign bus_if.out_passes = done_s ? pass_q : 3'd0;

endmodule

// File: tb/tb_fpaddsub_normalize_ctrl.sv
// Directed and randomized checks of the normalization sequencer against a
// pass-by-pass arithmetic model of the normalization rules.
module tb_fpaddsub_normalize_ctrl;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  fpaddsub_normalize_ctrl_if #(.MW(33), .EW(8)) bus ();

  // Shared combinational shifter lives outside the controller.
  assign bus.sh_mant_i = bus.sh_mant_o << bus.sh_amt_o;

  fpaddsub_normalize_ctrl #(.MW(33), .EW(8), .MAXSH(15)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_norm(input logic [32:0] m_in, input int e_in,
                                   output logic [32:0] m, output int e, output int p,
                                   output bit z, output bit d);
    int lz;
    int s;
    m = m_in; e = e_in; p = 0; z = 1'b0; d = 1'b0;
    if (m == 33'd0) begin
      z = 1'b1;
      e = 0;
      return;
    end
    for (int k = 0; k < 8; k++) begin
      lz = 0;
      for (int b = 32; b >= 0; b--) begin
        if (m[b]) break;
        lz++;
      end
      if (lz == 0 || e <= 1) break;
      s = lz;
      if (s > 15) s = 15;
      if (s > e - 1) s = e - 1;
      m = m << s;
      e = e - s;
      p++;
    end
    d = !m[32];
  endfunction

  task automatic run_op(input logic [32:0] m, input logic [7:0] e, input int hold, input string tag);
    logic [32:0] xm;
    int          xe, xp, n, w;
    bit          xz, xd;
    logic [32:0] snap_m;
    logic [7:0]  snap_e;
    ref_norm(m, int'(e), xm, xe, xp, xz, xd);
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    check({tag, ".ready_before"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_mant  = m;
    bus.in_exp   = e;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_mant  = {$urandom, $urandom};
    bus.in_exp   = 8'($urandom);
    check({tag, ".ready_busy"}, 64'(bus.in_ready), 64'd0);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check({tag, ".latency"}, 64'(n), 64'(2 * xp + 1));
    check({tag, ".mant"}, 64'(bus.out_mant), 64'(xm));
    check({tag, ".exp"}, 64'(bus.out_exp), 64'(xe));
    check({tag, ".zero"}, 64'(bus.out_zero), 64'(xz));
    check({tag, ".denorm"}, 64'(bus.out_denorm), 64'(xd));
    check({tag, ".passes"}, 64'(bus.out_passes), 64'(xp));
    check({tag, ".sh_amt_idle"}, 64'(bus.sh_amt_o), 64'd0);
    snap_m = bus.out_mant;
    snap_e = bus.out_exp;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, 64'(bus.out_valid), 64'd1);
      check({tag, ".hold_mant"}, 64'(bus.out_mant), 64'(snap_m));
      check({tag, ".hold_exp"}, 64'(bus.out_exp), 64'(snap_e));
      check({tag, ".hold_ready"}, 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, ".valid_drop"}, 64'(bus.out_valid), 64'd0);
    check({tag, ".ready_back"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    logic [65:0] r;
    logic [32:0] rm;
    logic [7:0]  re;
    compared      = 0;
    mismatched    = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_mant   = 33'd0;
    bus.in_exp    = 8'd0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("reset.in_ready", 64'(bus.in_ready), 64'd1);
    check("reset.out_valid", 64'(bus.out_valid), 64'd0);
    check("reset.out_mant", 64'(bus.out_mant), 64'd0);
    check("reset.out_exp", 64'(bus.out_exp), 64'd0);
    check("reset.sh_amt", 64'(bus.sh_amt_o), 64'd0);
    check("reset.passes", 64'(bus.out_passes), 64'd0);

    run_op(33'h1_0000_0000, 8'd100, 0, "c1");
    run_op(33'h0_0000_0001, 8'd100, 0, "c2");
    run_op(33'h0_0001_0000, 8'd5, 0, "c3");
    run_op(33'h0_0000_0000, 8'd77, 0, "c4");
    run_op(33'h0_0000_0001, 8'd100, 5, "c5");

    // Reset while the first shift pass of a 3-pass operand is in flight.
    bus.in_valid = 1'b1;
    bus.in_mant  = 33'h0_0000_0001;
    bus.in_exp   = 8'd100;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("c6.sh_amt_in_shift", 64'(bus.sh_amt_o), 64'd15);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("c6.valid_after_rst", 64'(bus.out_valid), 64'd0);
    check("c6.ready_after_rst", 64'(bus.in_ready), 64'd1);
    check("c6.sh_amt_after_rst", 64'(bus.sh_amt_o), 64'd0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("c6.no_partial", 64'(bus.out_valid), 64'd0);
    end
    run_op(33'h1_0000_0000, 8'd100, 0, "c6b");

    run_op(33'h0_4000_0000, 8'd0, 0, "exp0");
    run_op(33'h0_4000_0000, 8'd1, 0, "exp1");
    run_op(33'h0_4000_0000, 8'd2, 1, "exp2");
    run_op(33'h0_0000_8000, 8'd255, 0, "lz17");

    for (int t = 0; t < 60; t++) begin
      r  = {$urandom, $urandom, 2'($urandom)};
      rm = r[65:33] >> $urandom_range(0, 33);
      re = 8'($urandom_range(0, 255));
      if ((t % 7) == 0) re = 8'($urandom_range(0, 3));
      run_op(rm, re, $urandom_range(0, 2), $sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
